if_fetch: RTL

Instruction-fetch front end of the core. Generates the sequential PC, issues single-outstanding requests to the Icache, and delivers `{inst, pc, valid}` to the ID stage. It honours fc stall and redirect (jump/branch) commands, and discards any in-flight Icache response made stale by a redirect. This block is the supplying end of the instruction path that ID consumes.

---
 rtl/if_fetch_pkg.sv | 18 +
 rtl/if_fetch.sv | 117 +++++++++++
 2 files changed

// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

    typedef enum logic [1:0] {
        IfIdle    = 2'd0,
        IfIssue   = 2'd1,
        IfWait    = 2'd2,
        IfDiscard = 2'd3
    } if_state_e;

    localparam logic [31:0] IfResetPcDefault = 32'h0000_0000;
    localparam logic [31:0] IfInstBytes      = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: sequential PC, single-outstanding Icache requests, and an
// output register towards ID with stall hold and redirect flush.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IfResetPcDefault
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        if_Icache_req_o,
    output logic [31:0] if_Icache_addr_o,
    input  logic        Icache_ready_i,
    input  logic        Icache_data_valid_i,
    input  logic [31:0] Icache_inst_i,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o,
    output logic        if_inst_valid_o,
    input  logic        fc_stall_if_i,
    input  logic        fc_redirect_i,
    input  logic [31:0] fc_redirect_pc_i
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        valid_q, valid_d;
    logic        req;
    logic        load;
    logic [31:0] redirect_pc;

    assign redirect_pc = align_pc(fc_redirect_pc_i);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IfIdle: begin
                state_d = IfIssue;
            end
            IfIssue: begin
                req = !(valid_q && fc_stall_if_i);
                if (fc_redirect_i) begin
                    pc_d = redirect_pc;
                    // The old address was already accepted; its response must be dropped.
                    if (req && Icache_ready_i) begin
                        state_d = IfDiscard;
                    end
                end else if (req && Icache_ready_i) begin
                    state_d = IfWait;
                end
            end
            IfWait: begin
                if (fc_redirect_i) begin
                    pc_d    = redirect_pc;
                    state_d = Icache_data_valid_i ? IfIssue : IfDiscard;
                end else if (Icache_data_valid_i) begin
                    load    = 1'b1;
                    pc_d    = pc_q + IfInstBytes;
                    state_d = IfIssue;
                end
            end
            IfDiscard: begin
                if (fc_redirect_i) begin
                    pc_d = redirect_pc;
                end
                if (Icache_data_valid_i) begin
                    state_d = IfIssue;
                end
            end
            default: begin
                state_d = IfIdle;
            end
        endcase
    end

    // Redirect flushes the output ahead of both a new response and a stall hold.
    always_comb begin
        valid_d  = valid_q;
        inst_d   = inst_q;
        out_pc_d = out_pc_q;
        if (fc_redirect_i) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d  = 1'b1;
            inst_d   = Icache_inst_i;
            out_pc_d = pc_q;
        end else if (valid_q && !fc_stall_if_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IfIdle;
            pc_q     <= RESET_PC;
            inst_q   <= 32'h0;
            out_pc_q <= 32'h0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            out_pc_q <= out_pc_d;
            valid_q  <= valid_d;
        end
    end

    assign if_Icache_req_o  = req;
    assign if_Icache_addr_o = pc_q;
    assign if_inst_o        = inst_q;
    assign if_pc_o          = out_pc_q;
    assign if_inst_valid_o  = valid_q;

endmodule
